dpd_digit_serializer: RTL and testbench
=======================================

// Module: dpd_digit_serializer
// PURPOSE
// - Downstream consumer of the decimal codec stage. Takes a word of GROUPS Densely Packed Decimal declets.
// - Decodes each declet to three BCD digits per IEEE 754-2008 DPD.
// - Streams the digits out one per cycle, most significant first, over valid/ready.
// - Feeds digit-serial sinks (display scanners, UART decimal printers).
// PARAMETERS
// - GROUPS  default 2  declets per input word; digit count NDIG = 3*GROUPS.
// PORTS
// - clk          in   1           clock; all state changes on rising edge
// - rst_n        in   1           asynchronous active-low reset
// - in_valid     in   1           input word offered
// - in_ready     out  1           block can accept a word
// - in_dpd       in   10*GROUPS   declets; [10*GROUPS-1 -: 10] is most significant
// - out_valid    out  1           out_digit holds a digit
// - out_ready    in   1           sink accepts digit
// - out_digit    out  4           BCD digit, always 0..9
// - out_first    out  1           current digit is first emitted digit of word
// - out_last     out  1           current digit is last emitted digit of word
// - out_noncanon out  1           word held any non-canonical declet; stable for whole word
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; in_ready=1; all outputs 0; digit regs and index cleared.
// - FSM states IDLE and EMIT.
//   - IDLE: in_ready=1, out_valid=0.
//   - On in_valid&&in_ready: latch all decoded digits (NDIG x 4 bits), latch the noncanon flag, set index, go to EMIT.
// - EMIT
//   - Registered outputs: in_ready=0, out_valid=1, out_digit=digit[index] (index 0 = MSD).
//   - On out_valid&&out_ready:
//     - If index is the last digit, go to IDLE.
//     - Otherwise advance index by 1.
//   - While out_valid&&!out_ready, out_digit/first/last/noncanon stay stable.
// - Latency and throughput
//   - Word accepted at edge N gives first digit valid after edge N (cycle N+1).
//   - Last digit handshaken at edge M gives in_ready=1 in cycle M+1.
//   - No accept/emit overlap: one bubble per word, so a word costs NDIG+1 cycles minimum.
// - Decode: purely combinational from in_dpd, registered only at accept. Case on bits b3, b2..b1, b6..b5.
//   - b3=0: all three digits are small.
//   - b3=1: one, two or three large digits (8/9); the large digit's lsb comes from b7/b4/b0.
// - Non-canonical declet: b3..b1=111, b6..b5=11, b9..b8!=00. Decodes as if b9..b8=00 (24 encodings).
// - out_first/out_last are both 1 when only one digit is emitted.
// - No overflow or error path: all 1024 declet values decode to digits 0..9.
// CONFIGURATION
// - DPD_SERIAL_LZS_EN defined: leading-zero suppression.
//   - At accept, the index starts at the first nonzero digit.
//   - If all digits are 0, the index starts at NDIG-1, so a single '0' is emitted with first=last=1.
//   - out_first marks the first digit actually emitted.
// - DPD_SERIAL_LZS_EN undefined: index always starts at 0; exactly NDIG digits per word. No suppression logic is built.
// TESTING (GROUPS=2)
// 1. in_dpd={10'h0A3,10'h0FF}, out_ready=1
//    - out_digit 1,2,3,9,9,9 on consecutive cycles; first on '1', last on the final '9'; noncanon=0.
//    - in_ready=1 in the cycle after the last digit.
// 2. Same word, out_ready toggling 1,0,0,1,...
//    - Each digit held stable through stalls; sequence unchanged; no digit dropped or duplicated.
// 3. in_dpd={10'h3FF,10'h000}
//    - Digits 9,9,9,0,0,0; out_noncanon=1 for all six.
// 4. Reset pulsed low mid-word (after digit 2 of test 1)
//    - out_valid=0 and in_ready=1 immediately, with no clock edge.
//    - Next word {10'h000,10'h007} emits 0,0,0,0,0,7 (macro off).
// 5. Macro on, {10'h000,10'h007}
//    - Single digit 7 with first=last=1.
//    - {10'h000,10'h000} gives single 0 with first=last=1.
//    - {10'h0A3,10'h000} gives 1,2,3,0,0,0.
// 6. in_valid held high back-to-back with two words
//    - Second word accepted only in the IDLE cycle after the first word's last digit.
//    - in_ready=0 throughout EMIT.

Source files
------------

// File: rtl/dpd_digit_serializer.sv
// -----------------------------------------------------------------------------
// dpd_digit_serializer
//
// Purpose:
//   Accepts a word of GROUPS Densely Packed Decimal declets and decodes each
//   declet into three BCD digits (IEEE 754-2008 DPD). The digits are then
//   streamed out one per cycle, most significant digit first, over a
//   valid/ready handshake. Typical sinks are display scanners and UART
//   decimal printers.
//
// Configuration macro:
//   DPD_SERIAL_LZS_EN - when defined, leading zeros are suppressed. Emission
//                       starts at the first nonzero digit. An all-zero word
//                       emits a single '0'. When undefined, every word emits
//                       exactly NDIG digits and no suppression logic exists.
//
// Parameters:
//   GROUPS        declets per input word; NDIG = 3*GROUPS digits per word
//
// Ports:
//   clk           in   clock, rising edge active
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   input word offered
//   in_ready      out  block can accept a word (IDLE)
//   in_dpd        in   declets, [10*GROUPS-1 -: 10] is most significant
//   out_valid     out  out_digit holds a digit (EMIT)
//   out_ready     in   sink accepts the digit
//   out_digit     out  BCD digit 0..9
//   out_first     out  first emitted digit of the word
//   out_last      out  last emitted digit of the word
//   out_noncanon  out  word held a non-canonical declet; stable for the word
// -----------------------------------------------------------------------------
module dpd_digit_serializer #(
    parameter int GROUPS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [10*GROUPS-1:0]  in_dpd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_digit,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  out_noncanon
);

    localparam int NDIG  = 3 * GROUPS;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NDIG-1:0][3:0]   r_digits;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_first;
    logic                   r_noncanon;

    logic [NDIG-1:0][3:0]   w_dec;
    logic                   w_noncanon;
    logic [IDX_W-1:0]       w_start;
    logic                   w_accept;
    logic                   w_advance;
    logic                   w_at_last;

    // Decode one declet into {hundreds, tens, units}. Large digits (8/9)
    // take their lsb from b7/b4/b0; the remaining small digits pick up
    // whichever 2-bit fields the indicator bits free up.
    function automatic logic [11:0] dpd_decode(input logic [9:0] d);
        logic [3:0] h;
        logic [3:0] m;
        logic [3:0] l;
        h = {1'b0, d[9:7]};
        m = {1'b0, d[6:4]};
        l = {1'b0, d[2:0]};
        if (d[3]) begin
            case (d[2:1])
                2'b00: l = {3'b100, d[0]};
                2'b01: begin
                    m = {3'b100, d[4]};
                    l = {1'b0, d[6:5], d[0]};
                end
                2'b10: begin
                    h = {3'b100, d[7]};
                    l = {1'b0, d[9:8], d[0]};
                end
                default: begin
                    case (d[6:5])
                        2'b00: begin
                            h = {3'b100, d[7]};
                            m = {3'b100, d[4]};
                            l = {1'b0, d[9:8], d[0]};
                        end
                        2'b01: begin
                            h = {3'b100, d[7]};
                            m = {1'b0, d[9:8], d[4]};
                            l = {3'b100, d[0]};
                        end
                        2'b10: begin
                            m = {3'b100, d[4]};
                            l = {3'b100, d[0]};
                        end
                        default: begin
                            // b9..b8 are don't-care here; nonzero values are
                            // the non-canonical encodings.
                            h = {3'b100, d[7]};
                            m = {3'b100, d[4]};
                            l = {3'b100, d[0]};
                        end
                    endcase
                end
            endcase
        end
        return {h, m, l};
    endfunction

    function automatic logic is_noncanon(input logic [9:0] d);
        return (d[3:1] == 3'b111) && (d[6:5] == 2'b11) && (d[9:8] != 2'b00);
    endfunction

    always_comb begin
        w_dec      = '0;
        w_noncanon = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            {w_dec[3*g], w_dec[3*g+1], w_dec[3*g+2]} =
                dpd_decode(in_dpd[10*(GROUPS-g)-1 -: 10]);
            w_noncanon = w_noncanon | is_noncanon(in_dpd[10*(GROUPS-g)-1 -: 10]);
        end
    end

`ifdef DPD_SERIAL_LZS_EN
    // Scan from the LSD upward so the lowest index (MSD side) nonzero wins;
    // an all-zero word falls back to the final digit.
    always_comb begin
        w_start = LAST_IDX;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (w_dec[i] != 4'd0) begin
                w_start = IDX_W'(i);
            end
        end
    end
`else
    assign w_start = '0;
`endif

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == EMIT);
    assign out_digit    = r_digits[r_idx];
    assign out_first    = out_valid & r_first;
    assign out_last     = out_valid & w_at_last;
    assign out_noncanon = out_valid & r_noncanon;

    assign w_at_last = (r_idx == LAST_IDX);
    assign w_accept  = in_valid & in_ready;
    assign w_advance = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = EMIT;
            EMIT: if (w_advance && w_at_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits   <= '0;
            r_idx      <= '0;
            r_first    <= 1'b0;
            r_noncanon <= 1'b0;
        end else if (w_accept) begin
            r_digits   <= w_dec;
            r_idx      <= w_start;
            r_first    <= 1'b1;
            r_noncanon <= w_noncanon;
        end else if (w_advance) begin
            r_first <= 1'b0;
            if (!w_at_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpd_digit_serializer.sv
module tb_dpd_digit_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_dpd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_digit;
    logic        out_first;
    logic        out_last;
    logic        out_noncanon;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected digits are left-justified hex nibbles: digs[23:20] is emitted first.
    typedef struct {
        logic [19:0] dpd;
        int          n;
        logic [23:0] digs;
        logic        nc;
    } vec_t;

    vec_t vecs[9];

    dpd_digit_serializer #(.GROUPS(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dpd       (in_dpd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_digit    (out_digit),
        .out_first    (out_first),
        .out_last     (out_last),
        .out_noncanon (out_noncanon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] a, input logic [9:0] b,
                                input int n, input logic [23:0] digs, input logic nc);
        vec_t v;
        v.dpd  = {a, b};
        v.n    = n;
        v.digs = digs;
        v.nc   = nc;
        return v;
    endfunction

    // Called right after a rising edge (+1) with the DUT idle.
    task automatic run_word(input vec_t v, input bit stall, input string tag);
        int  k;
        int  cyc;
        bit  rdy;
        chk($sformatf("%s.idle_in_ready", tag), in_ready, 1);
        chk($sformatf("%s.idle_out_valid", tag), out_valid, 0);
        in_valid = 1'b1;
        in_dpd   = v.dpd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < v.n && cyc < 64) begin
            rdy = stall ? ((cyc % 3) == 0) : 1'b1;
            out_ready = rdy;
            chk($sformatf("%s.d%0d.out_valid", tag, k), out_valid, 1);
            chk($sformatf("%s.d%0d.in_ready", tag, k), in_ready, 0);
            chk($sformatf("%s.d%0d.digit", tag, k), out_digit, int'(v.digs[23-4*k -: 4]));
            chk($sformatf("%s.d%0d.first", tag, k), out_first, (k == 0) ? 1 : 0);
            chk($sformatf("%s.d%0d.last", tag, k), out_last, (k == v.n - 1) ? 1 : 0);
            chk($sformatf("%s.d%0d.noncanon", tag, k), out_noncanon, int'(v.nc));
            @(posedge clk); #1;
            if (rdy) k++;
            cyc++;
        end
        out_ready = 1'b1;
        chk($sformatf("%s.digit_count", tag), k, v.n);
        chk($sformatf("%s.after_in_ready", tag), in_ready, 1);
        chk($sformatf("%s.after_out_valid", tag), out_valid, 0);
    endtask

    initial begin
        vecs[0] = mk(10'h0A3, 10'h0FF, 6, 24'h123999, 1'b0);
        vecs[1] = mk(10'h3FF, 10'h000, 6, 24'h999000, 1'b1);
        vecs[2] = mk(10'h2AB, 10'h1AD, 6, 24'h583923, 1'b0);
        vecs[3] = mk(10'h39F, 10'h149, 6, 24'h997249, 1'b0);
        vecs[4] = mk(10'h1BF, 10'h2CE, 6, 24'h939588, 1'b0);
        vecs[5] = mk(10'h0A3, 10'h000, 6, 24'h123000, 1'b0);
`ifdef DPD_SERIAL_LZS_EN
        vecs[6] = mk(10'h000, 10'h36F, 3, 24'h889000, 1'b1);
        vecs[7] = mk(10'h000, 10'h007, 1, 24'h700000, 1'b0);
        vecs[8] = mk(10'h000, 10'h000, 1, 24'h000000, 1'b0);
`else
        vecs[6] = mk(10'h000, 10'h36F, 6, 24'h000889, 1'b1);
        vecs[7] = mk(10'h000, 10'h007, 6, 24'h000007, 1'b0);
        vecs[8] = mk(10'h000, 10'h000, 6, 24'h000000, 1'b0);
`endif

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_digit", out_digit, 0);
        chk("rst.out_first", out_first, 0);
        chk("rst.out_last", out_last, 0);
        chk("rst.out_noncanon", out_noncanon, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven words, sink always ready
        for (int i = 0; i < 9; i++) begin
            run_word(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Stalling sink: ready pattern 1,0,0,1,0,0,...
        run_word(vecs[0], 1'b1, "stall");

        // Asynchronous reset in the middle of a word
        in_valid = 1'b1;
        in_dpd   = vecs[0].dpd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst.pre_digit", out_digit, 3);
        chk("midrst.pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.out_digit", out_digit, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(vecs[7], 1'b0, "postrst");

        // Back-to-back words with in_valid held high
        in_valid = 1'b1;
        in_dpd   = vecs[2].dpd;
        @(posedge clk); #1;
        in_dpd   = vecs[3].dpd;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b.w1.d%0d.in_ready", k), in_ready, 0);
            chk($sformatf("b2b.w1.d%0d.digit", k), out_digit, int'(vecs[2].digs[23-4*k -: 4]));
            @(posedge clk); #1;
        end
        chk("b2b.bubble.in_ready", in_ready, 1);
        chk("b2b.bubble.out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b.w2.out_valid", out_valid, 1);
        chk("b2b.w2.first", out_first, 1);
        chk("b2b.w2.digit", out_digit, 9);
        chk("b2b.w2.in_ready", in_ready, 0);
        for (int c = 0; c < 20 && out_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("b2b.drain", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
